// File: rtl/decode_queue.sv
// decode_queue: decode stage between fetch and execute of the MIPS core.
//   A DEPTH-entry circular FIFO buffers {pc, instr} pairs from fetch. The
//   head entry is decoded combinationally into an instruction class,
//   register fields and an extended immediate, and is offered downstream
//   with a valid/ready handshake. A flush discards every buffered entry.
//
// Optional feature: define DECODE_TRAP_EN to stall on an unknown opcode.
//   The head is then held with out_trap=1 until flush or reset.
//   When the macro is undefined, out_trap is tied to 0.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   flush                 drop all entries (redirect)
//   in_valid/in_ready     fetch handshake; in_pc, in_instr carry the entry
//   out_valid/out_ready   execute handshake for the head entry
//   out_pc, out_instr     head entry
//   out_class             0 UNKNOWN 1 RTYPE 2 BRANCH 3 JUMP 4 ALU_IMM 5 LOAD 6 STORE
//   out_rs/rt/rd          instr[25:21] / [20:16] / [15:11]
//   out_imm               extended immediate
//   out_trap              unknown-instruction trap
module decode_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic [31:0]         in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [31:0]         out_instr,
  output logic [2:0]          out_class,
  output logic [4:0]          out_rs,
  output logic [4:0]          out_rt,
  output logic [4:0]          out_rd,
  output logic [31:0]         out_imm,
  output logic                out_trap
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    CLS_UNKNOWN = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_BRANCH  = 3'd2,
    CLS_JUMP    = 3'd3,
    CLS_ALU_IMM = 3'd4,
    CLS_LOAD    = 3'd5,
    CLS_STORE   = 3'd6
  } cls_e;

  function automatic cls_e decode_class(input logic [5:0] op);
    cls_e c;
    case (op)
      6'h00:                                     c = CLS_RTYPE;
      6'h04, 6'h05:                              c = CLS_BRANCH;
      6'h02, 6'h03:                              c = CLS_JUMP;
      6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
      6'h0F:                                     c = CLS_ALU_IMM;
      6'h23:                                     c = CLS_LOAD;
      6'h2B:                                     c = CLS_STORE;
      default:                                   c = CLS_UNKNOWN;
    endcase
    return c;
  endfunction

  // Logical immediates zero-extend, LUI shifts up, jumps form a word
  // target; everything else is a signed 16-bit offset/immediate.
  function automatic logic [31:0] decode_imm(input logic [31:0] instr);
    logic signed [15:0] simm;
    logic signed [31:0] sext;
    logic [31:0]        imm;
    simm = signed'(instr[15:0]);
    sext = simm;
    case (instr[31:26])
      6'h0C, 6'h0D, 6'h0E: imm = {16'h0000, instr[15:0]};
      6'h0F:               imm = {instr[15:0], 16'h0000};
      6'h02, 6'h03:        imm = {4'h0, instr[25:0], 2'b00};
      default:             imm = unsigned'(sext);
    endcase
    return imm;
  endfunction

  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
  logic [31:0]         instr_mem [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  cls_e          head_cls;

  // Handshake flags come from the registered count only, so in_ready has
  // no combinational dependence on out_ready.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);

  assign out_pc    = pc_mem[head_q];
  assign out_instr = instr_mem[head_q];
  assign head_cls  = decode_class(out_instr[31:26]);
  assign out_class = head_cls;
  assign out_rs    = out_instr[25:21];
  assign out_rt    = out_instr[20:16];
  assign out_rd    = out_instr[15:11];
  assign out_imm   = decode_imm(out_instr);

`ifdef DECODE_TRAP_EN
  // A trapped head stays put until a flush or reset clears the queue.
  assign out_trap = out_valid && (head_cls == CLS_UNKNOWN);
`else
  assign out_trap = 1'b0;
`endif

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !out_trap;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; a write during flush lands in a slot
  // that the cleared count already marks as empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]    <= in_pc;
      instr_mem[tail_q] <= in_instr;
    end
  end

endmodule
